// File: rtl/uart_tx_periph_pkg.sv
// Shared register map, status/control bit positions and TX FSM encoding for the UART TX peripheral.
package uart_tx_periph_pkg;

    localparam logic [31:0] UART_BASE_ADDR = 32'hC000_0000;

    // Register index = bus_addr[3:2]
    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_BAUD   = 2'd2;
    localparam logic [1:0] UART_CTRL   = 2'd3;

    localparam int ST_BUSY_BIT     = 0;
    localparam int ST_FULL_BIT     = 1;
    localparam int ST_EMPTY_BIT    = 2;
    localparam int ST_OVF_BIT      = 3;
    localparam int ST_COUNT_LSB    = 8;
    localparam int CTRL_TX_EN_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] status_word(input logic busy, input logic full,
                                                input logic empty, input logic ovf,
                                                input logic [23:0] count);
        return {count, 4'b0000, ovf, empty, full, busy};
    endfunction

endpackage

// File: rtl/uart_tx_periph_if.sv
// Core IO bus as seen by a memory-mapped peripheral: address/data/strobe in, registered read data out.
interface uart_tx_periph_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/uart_tx_periph_sync_fifo.sv
// Synchronous FIFO with fall-through read data; a push into a full FIFO is accepted when a pop frees a slot in the same cycle.
module uart_tx_periph_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and programmable baud divider.
// Optional interrupt output when UART_IRQ_EN is defined.
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = UART_BASE_ADDR,
    parameter int          FIFO_AW     = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_periph_if.slave   bus,
    output logic              tx
`ifdef UART_IRQ_EN
    ,
    output logic              irq
`endif
);
    logic           sel, wr;
    logic [1:0]     reg_idx;
    logic [15:0]    baud_div;
    logic           ctrl_tx_en, ctrl_irq_rd, overflow;
    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]     fifo_rdata;
    logic [FIFO_AW:0] fifo_count;
    tx_state_e      state;
    logic [15:0]    div_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic           bit_done, start_frame;
    logic [31:0]    rd_word;
    logic           unused_bits;

    assign sel       = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx   = bus.addr[3:2];
    assign wr        = sel && bus.we;
    assign fifo_push = wr && (reg_idx == UART_TXDATA);
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:16]};

    uart_tx_periph_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_sync_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (bus.wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A frame may begin from IDLE or straight out of a finished stop bit.
    assign bit_done    = (div_cnt == '0);
    assign start_frame = ctrl_tx_en && !fifo_empty &&
                         ((state == TX_IDLE) || ((state == TX_STOP) && bit_done));
    assign fifo_pop    = start_frame;

`ifdef UART_IRQ_EN
    logic ctrl_irq_en;
    assign ctrl_irq_rd = ctrl_irq_en;

    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= ctrl_irq_en && fifo_empty && (state == TX_IDLE);
    end
`else
    assign ctrl_irq_rd = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_div   <= DEFAULT_DIV;
            ctrl_tx_en <= 1'b0;
`ifdef UART_IRQ_EN
            ctrl_irq_en <= 1'b0;
`endif
        end else if (wr) begin
            if (reg_idx == UART_BAUD) baud_div <= bus.wdata[15:0];
            if (reg_idx == UART_CTRL) begin
                ctrl_tx_en <= bus.wdata[CTRL_TX_EN_BIT];
`ifdef UART_IRQ_EN
                ctrl_irq_en <= bus.wdata[CTRL_IRQ_EN_BIT];
`endif
            end
        end
    end

    // Overflow only when the dropped byte found no slot, even after a same-cycle pop.
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (fifo_push && fifo_full && !fifo_pop)
            overflow <= 1'b1;
        else if (wr && (reg_idx == UART_STATUS) && bus.wdata[ST_OVF_BIT])
            overflow <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            tx      <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (start_frame) begin
                        state   <= TX_START;
                        tx      <= 1'b0;
                        shift   <= fifo_rdata;
                        div_cnt <= baud_div;
                    end
                end
                TX_START: begin
                    if (bit_done) begin
                        state   <= TX_DATA;
                        tx      <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= '0;
                        div_cnt <= baud_div;
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (bit_done) begin
                        div_cnt <= baud_div;
                        if (bit_cnt == 3'd7) begin
                            state <= TX_STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx      <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (bit_done) begin
                        if (start_frame) begin
                            state   <= TX_START;
                            tx      <= 1'b0;
                            shift   <= fifo_rdata;
                            div_cnt <= baud_div;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= TX_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        case (reg_idx)
            UART_STATUS: rd_word = status_word(state != TX_IDLE, fifo_full, fifo_empty,
                                               overflow, 24'(fifo_count));
            UART_BAUD:   rd_word = {16'h0000, baud_div};
            UART_CTRL:   rd_word = {30'h0, ctrl_irq_rd, ctrl_tx_en};
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) bus.rdata <= '0;
        else     bus.rdata <= sel ? rd_word : 32'h0;
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: queue/bit-list reference model checked every cycle, plus hand-computed waveform and register literals.
module tb_uart_tx_periph;

    localparam logic [31:0] A_TX = 32'hC000_0000;
    localparam logic [31:0] A_ST = 32'hC000_0004;
    localparam logic [31:0] A_BD = 32'hC000_0008;
    localparam logic [31:0] A_CT = 32'hC000_000C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
`ifdef UART_IRQ_EN
    logic irq;
    logic exp_irq;
`endif

    uart_tx_periph_if bus();

    uart_tx_periph dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
`ifdef UART_IRQ_EN
        ,
        .irq (irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue, per-frame bit list, clocks remaining in the current bit.
    logic [7:0]  mq[$];
    logic [15:0] m_div;
    logic        m_en, m_irqen, m_ovf, m_valid = 1'b0;
    int          m_idx, m_left;
    logic [9:0]  m_bits;
    logic        exp_tx;
    logic [31:0] exp_rdata;

    always @(posedge clk) begin
        logic        sel;
        logic [1:0]  r;
        logic [31:0] rv;
        logic [7:0]  b;
        if (rst) begin
            mq.delete();
            m_div = 16'd867; m_en = 0; m_irqen = 0; m_ovf = 0;
            m_idx = -1; m_left = 0; m_bits = '1;
            exp_tx = 1'b1; exp_rdata = '0; m_valid = 1'b1;
`ifdef UART_IRQ_EN
            exp_irq = 1'b0;
`endif
        end else begin
            sel = (bus.addr[31:4] == 28'hC00_0000);
            r   = bus.addr[3:2];
            rv  = '0;
            case (r)
                2'd1: begin
                    rv[0]    = (m_idx >= 0);
                    rv[1]    = (mq.size() == 16);
                    rv[2]    = (mq.size() == 0);
                    rv[3]    = m_ovf;
                    rv[12:8] = 5'(mq.size());
                end
                2'd2: rv = {16'h0, m_div};
                2'd3: begin rv[0] = m_en; rv[1] = m_irqen; end
                default: rv = '0;
            endcase
            exp_rdata = sel ? rv : 32'h0;
`ifdef UART_IRQ_EN
            exp_irq = m_irqen && (mq.size() == 0) && (m_idx < 0);
`endif
            if (m_idx >= 0 && m_left > 0) begin
                m_left--;
            end else if (m_idx >= 0 && m_idx < 9) begin
                m_idx++;
                m_left = int'(m_div);
            end else if (m_en && mq.size() > 0) begin
                b = mq.pop_front();
                m_bits = {1'b1, b, 1'b0};
                m_idx = 0;
                m_left = int'(m_div);
            end else begin
                m_idx = -1;
            end
            if (sel && bus.we) begin
                case (r)
                    2'd0: if (mq.size() < 16) mq.push_back(bus.wdata[7:0]); else m_ovf = 1'b1;
                    2'd1: if (bus.wdata[3]) m_ovf = 1'b0;
                    2'd2: m_div = bus.wdata[15:0];
                    default: begin
                        m_en = bus.wdata[0];
`ifdef UART_IRQ_EN
                        m_irqen = bus.wdata[1];
`endif
                    end
                endcase
            end
            exp_tx = (m_idx < 0) ? 1'b1 : m_bits[m_idx];
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_tx", 64'(tx), 64'(exp_tx));
            check("cyc_rdata", 64'(bus.rdata), 64'(exp_rdata));
`ifdef UART_IRQ_EN
            check("cyc_irq", 64'(irq), 64'(exp_irq));
`endif
        end
    end

    // Bus tasks start and end on a negedge so consecutive calls are back-to-back cycles.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.wdata = d; bus.we = 1'b1;
        @(negedge clk);
        bus.we = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a; bus.we = 1'b0;
        @(negedge clk);
        d = bus.rdata; bus.addr = 32'h0;
    endtask

    task automatic wait_low(input string name);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(tx), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [9:0]  pat;
        logic [39:0] s40, e40;
        logic [19:0] s20;
        bus.addr = 32'h0; bus.wdata = 32'h0; bus.we = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_tx", 64'(tx), 64'd1);
        rd(A_ST, d); check("reset_status", 64'(d), 64'h4);
        rd(A_BD, d); check("reset_baud", 64'(d), 64'h363);
        rd(32'hC000_0014, d); check("unselected_read", 64'(d), 64'h0);

        // 0x55 at 4 clocks per bit
        wr(A_BD, 32'd3);
        wr(A_CT, 32'd1);
        wr(A_TX, 32'h55);
        wait_low("frame55_start");
        s40 = '0;
        s40[0] = tx;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            s40[i] = tx;
            if (i == 1) bus.addr = A_ST;
            if (i == 2) begin
                check("busy_mid_frame", 64'(bus.rdata), 64'h5);
                bus.addr = 32'h0;
            end
        end
        pat = 10'b1010101010;
        for (int k = 0; k < 40; k++) e40[k] = pat[k/4];
        check("frame55_wave", 64'(s40), 64'(e40));
        repeat (2) @(negedge clk);
        rd(A_ST, d); check("idle_after_frame", 64'(d), 64'h4);

        // Overflow on the 17th byte, then clear it
        wr(A_CT, 32'd0);
        for (int i = 0; i < 17; i++) wr(A_TX, 32'(i + 8'h30));
        rd(A_ST, d); check("full_overflow", 64'(d), 64'h100A);
        wr(A_ST, 32'h8);
        rd(A_ST, d); check("overflow_cleared", 64'(d), 64'h1002);
        rd(A_BD, d); check("baud_readback", 64'(d), 64'h3);

        // Push into full FIFO on the same cycle the FSM pops
        wr(A_BD, 32'd0);
        wr(A_CT, 32'd1);
        wr(A_TX, 32'h77);
        rd(A_ST, d); check("full_push_with_pop", 64'(d), 64'h1003);
        repeat (200) @(negedge clk);
        rd(A_ST, d); check("drained", 64'(d), 64'h4);

        // Reset in the middle of a data bit
        wr(A_BD, 32'd3);
        wr(A_TX, 32'h11);
        wr(A_TX, 32'h22);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid_frame_tx", 64'(tx), 64'd1);
        rd(A_ST, d); check("reset_mid_frame_status", 64'(d), 64'h4);
        rd(A_BD, d); check("reset_mid_frame_baud", 64'(d), 64'h363);
        rd(A_CT, d); check("reset_mid_frame_ctrl", 64'(d), 64'h0);

        // Back-to-back frames at 1 clock per bit
        wr(A_BD, 32'd0);
        wr(A_TX, 32'hA5);
        wr(A_TX, 32'h3C);
        wr(A_CT, 32'd1);
        wait_low("b2b_start");
        s20 = '0;
        s20[0] = tx;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            s20[i] = tx;
        end
        check("b2b_wave", 64'(s20), 64'({10'b1001111000, 10'b1101001010}));
        check("stop_then_start", 64'({s20[9], s20[10]}), 64'b10);
        repeat (5) @(negedge clk);

        wr(A_CT, 32'd3);
        rd(A_CT, d);
`ifdef UART_IRQ_EN
        check("ctrl_irq_bit", 64'(d), 64'h3);
        @(negedge clk);
        check("irq_idle_high", 64'(irq), 64'd1);
        wr(A_TX, 32'h5A);
        @(negedge clk);
        check("irq_falls", 64'(irq), 64'd0);
        repeat (15) @(negedge clk);
        check("irq_after_stop", 64'(irq), 64'd1);
`else
        check("ctrl_irq_bit", 64'(d), 64'h1);
`endif
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
